// File: rtl/shift_counter_if.sv
// Control and status bundle for shift_counter: the stimulus side drives the controls,
// and the counter returns out, tc and err.
interface shift_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             err;

  // No valid/ready handshake: en, load and mode changes are single-cycle qualifiers.
  // Each one is acted on at the rising edge where it is sampled high or changed.
  modport master (
    output en, mode, dir, load, load_val,
    input  out, tc, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output out, tc, err
  );
endinterface

// File: rtl/shift_counter.sv
// Ring / Johnson shift counter with load, direction control, terminal-count pulse and a legality flag.
// Optional macro SHIFT_COUNTER_SELF_CORRECT_EN reseeds on an en step taken from an illegal state.
module shift_counter #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  shift_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_out;
  logic             r_mode_q;
  logic             r_tc;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_seed_new;
  logic [WIDTH-1:0] w_seed_cur;
  logic             w_ring_one;
  logic             w_ring_multi;
  logic             w_jc_one;
  logic             w_jc_multi;
  logic             w_legal;
  logic             w_recover;

  assign w_seed_new = bus.mode ? '0 : RING_SEED;
  assign w_seed_cur = r_mode_q ? '0 : RING_SEED;

  always_comb begin
    w_step = r_out;
    case ({r_mode_q, bus.dir})
      2'b00: w_step = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
      2'b01: w_step = {r_out[0], r_out[WIDTH-1:1]};
      2'b10: w_step = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
      2'b11: w_step = {~r_out[0], r_out[WIDTH-1:1]};
      default: w_step = r_out;
    endcase
  end

  // Ring legality: exactly one bit set.
  // Johnson legality: at most one adjacent-bit boundary.
  always_comb begin
    w_ring_one   = 1'b0;
    w_ring_multi = 1'b0;
    w_jc_one     = 1'b0;
    w_jc_multi   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_out[i]) begin
        w_ring_multi = w_ring_multi | w_ring_one;
        w_ring_one   = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (r_out[i] != r_out[i+1]) begin
        w_jc_multi = w_jc_multi | w_jc_one;
        w_jc_one   = 1'b1;
      end
    end
    w_legal = r_mode_q ? ~w_jc_multi : (w_ring_one & ~w_ring_multi);
  end

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
  assign w_recover = ~w_legal;
`else
  assign w_recover = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= w_seed_new;
      r_mode_q <= bus.mode;
      r_tc     <= 1'b0;
    end else if (bus.load) begin
      r_out    <= bus.load_val;
      r_mode_q <= bus.mode;
      r_tc     <= 1'b0;
    end else if (bus.mode != r_mode_q) begin
      r_out    <= w_seed_new;
      r_mode_q <= bus.mode;
      r_tc     <= 1'b0;
    end else if (bus.en) begin
      if (w_recover) begin
        r_out <= w_seed_cur;
        r_tc  <= 1'b0;
      end else begin
        r_out <= w_step;
        r_tc  <= (w_step == w_seed_cur);
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.out = r_out;
  assign bus.tc  = r_tc;
  assign bus.err = ~w_legal;
endmodule

// File: tb/tb_shift_counter.sv
// Bench for shift_counter: reference model feeding an expected queue, directed
// scenarios with literal expectations, then a random phase.
module tb_shift_counter;
  localparam int WIDTH = 4;
  localparam int PW    = WIDTH + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_counter_if #(.WIDTH(WIDTH)) bus ();

  shift_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected entries are packed {err, tc, out}
  logic [PW-1:0]    exp_q[$];
  logic [WIDTH-1:0] m_out;
  logic             m_mode;
  logic             m_tc;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_seed(input logic md);
    logic [WIDTH-1:0] s;
    s = '0;
    if (!md) s[0] = 1'b1;
    return s;
  endfunction

  // Johnson legality by walking the 2*WIDTH reachable states from the seed.
  function automatic logic m_legal(input logic [WIDTH-1:0] v, input logic md);
    logic [WIDTH-1:0] s;
    if (!md) return ($countones(v) == 1);
    s = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (v == s) return 1'b1;
      s = {s[WIDTH-2:0], ~s[WIDTH-1]};
    end
    return 1'b0;
  endfunction

  function automatic logic [WIDTH-1:0] m_shift(input logic [WIDTH-1:0] v, input logic md, input logic d);
    if (!md && !d) return {v[WIDTH-2:0], v[WIDTH-1]};
    if (!md &&  d) return {v[0], v[WIDTH-1:1]};
    if ( md && !d) return {v[WIDTH-2:0], ~v[WIDTH-1]};
    return {~v[0], v[WIDTH-1:1]};
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic md, input logic d,
                            input logic l, input logic [WIDTH-1:0] lv);
    logic was_legal;
    was_legal = m_legal(m_out, m_mode);
    if (r) begin
      m_out = m_seed(md); m_mode = md; m_tc = 1'b0;
    end else if (l) begin
      m_out = lv; m_mode = md; m_tc = 1'b0;
    end else if (md != m_mode) begin
      m_out = m_seed(md); m_mode = md; m_tc = 1'b0;
    end else if (e) begin
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
      if (!was_legal) begin
        m_out = m_seed(m_mode); m_tc = 1'b0;
      end else begin
        m_out = m_shift(m_out, m_mode, d); m_tc = (m_out == m_seed(m_mode));
      end
`else
      m_out = m_shift(m_out, m_mode, d);
      m_tc  = (m_out == m_seed(m_mode));
`endif
    end else begin
      m_tc = 1'b0;
    end
  endtask

  // Drive one edge from the negedge, push the model result, compare after the edge.
  task automatic cycle(input logic r, input logic e, input logic md, input logic d,
                       input logic l, input logic [WIDTH-1:0] lv);
    logic [PW-1:0] exp;
    rst = r; bus.en = e; bus.mode = md; bus.dir = d; bus.load = l; bus.load_val = lv;
    model_edge(r, e, md, d, l, lv);
    exp_q.push_back({~m_legal(m_out, m_mode), m_tc, m_out});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("sb_out", PW'(bus.out), PW'(exp[WIDTH-1:0]));
    check("sb_tc",  PW'(bus.tc),  PW'(exp[WIDTH]));
    check("sb_err", PW'(bus.err), PW'(exp[WIDTH+1]));
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] ring_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                     4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [WIDTH-1:0] jc_seq   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                     4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;
    m_out = '0; m_mode = 1'b0; m_tc = 1'b0;
    @(negedge clk);

    // Ring count from reset
    cycle(1, 0, 0, 0, 0, '0);
    check("rst_out", PW'(bus.out), PW'(4'b0001));
    check("rst_tc",  PW'(bus.tc),  PW'(1'b0));
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 0, '0);
      check("ring_out", PW'(bus.out), PW'(ring_seq[i]));
      check("ring_tc",  PW'(bus.tc),  PW'((i == 3 || i == 7) ? 1'b1 : 1'b0));
      check("ring_err", PW'(bus.err), PW'(1'b0));
    end

    // Johnson count from reset
    cycle(1, 0, 1, 0, 0, '0);
    check("jrst_out", PW'(bus.out), PW'(4'b0000));
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, 0, 0, '0);
      check("jc_out", PW'(bus.out), PW'(jc_seq[i]));
      check("jc_tc",  PW'(bus.tc),  PW'((i == 7) ? 1'b1 : 1'b0));
    end

    // Direction change mid-sequence
    cycle(1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, '0);
    check("dir_pre", PW'(bus.out), PW'(4'b0111));
    cycle(0, 1, 1, 1, 0, '0);
    check("dir_back", PW'(bus.out), PW'(4'b0011));
    cycle(0, 1, 1, 0, 0, '0);
    check("dir_fwd", PW'(bus.out), PW'(4'b0111));

    // Mode change beats en; illegal load raises err
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, '0);
    check("mc_pre", PW'(bus.out), PW'(4'b0100));
    cycle(0, 1, 1, 0, 0, '0);
    check("mc_out", PW'(bus.out), PW'(4'b0000));
    check("mc_tc",  PW'(bus.tc),  PW'(1'b0));
    cycle(0, 0, 1, 0, 1, 4'b1010);
    check("ld_out", PW'(bus.out), PW'(4'b1010));
    check("ld_err", PW'(bus.err), PW'(1'b1));

    // Step from an illegal ring pattern
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, 4'b0110);
    check("ill_err", PW'(bus.err), PW'(1'b1));
    cycle(0, 1, 0, 0, 0, '0);
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    check("sc_out", PW'(bus.out), PW'(4'b0001));
    check("sc_tc",  PW'(bus.tc),  PW'(1'b0));
    check("sc_err", PW'(bus.err), PW'(1'b0));
`else
    check("ns_out", PW'(bus.out), PW'(4'b1100));
    check("ns_err", PW'(bus.err), PW'(1'b1));
`endif

    // Reset beats load; en held through release
    cycle(1, 0, 1, 0, 0, '0);
    cycle(0, 1, 1, 0, 0, '0);
    cycle(0, 1, 1, 0, 0, '0);
    cycle(1, 1, 1, 0, 1, 4'b1111);
    check("rl_out", PW'(bus.out), PW'(4'b0000));
    check("rl_tc",  PW'(bus.tc),  PW'(1'b0));
    cycle(0, 1, 1, 0, 0, '0);
    check("rl_step", PW'(bus.out), PW'(4'b0001));

    // Random phase against the model
    for (int i = 0; i < 400; i++) begin
      logic r, e, md, d, l;
      logic [WIDTH-1:0] lv;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 14) == 0);
      md = ($urandom_range(0, 19) == 0) ? ~m_mode : m_mode;
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      lv = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      cycle(r, e, md, d, l, lv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
